// File: rtl/alu_seq_pkg.sv
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types and opcode constants for the ALU command
//                sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } seq_state_t;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } alu_cmd_t;

    localparam int CMD_W = $bits(alu_cmd_t);

    // Opcodes above SUB have no ALU meaning.
    function automatic logic is_illegal_op(input logic [2:0] op);
        return (op > OP_SUB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
// ============================================================================
//  Module      : alu_cmd_fifo
//  Description : Synchronous FIFO holding pending ALU commands (power-of-two
//                depth, head presented combinationally).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head_ptr;
    logic [PTR_W-1:0] r_tail_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_count    <= '0;
        end else begin
            if (w_do_push) r_tail_ptr <= r_tail_ptr + 1'b1;
            if (w_do_pop)  r_head_ptr <= r_head_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_tail_ptr] <= push_data;
    end

    assign head  = r_mem[r_head_ptr];
    assign count = r_count;
    assign full  = (r_count == C_FULL_COUNT);
    assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : Queues (A,B,op) commands, issues them one at a time to a
//                registered 4-bit ALU and returns tagged results. Optional
//                illegal-opcode filtering via ALU_SEQ_ILLEGAL_FILTER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [3:0]       alu_c,
    input  logic             alu_cf,
    input  logic             alu_zf,
    input  logic             alu_sf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_c,
    output logic             rsp_cf,
    output logic             rsp_zf,
    output logic             rsp_sf,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic             err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    alu_cmd_t         w_push_cmd;
    alu_cmd_t         w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_cmd_hs;
    logic             w_push;
    logic             w_pop;
    logic             w_capture;
    logic             w_rsp_hs;
    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic             r_rsp_valid;
    logic [3:0]       r_rsp_c;
    logic             r_rsp_cf;
    logic             r_rsp_zf;
    logic             r_rsp_sf;
    logic [TAG_W-1:0] r_rsp_tag;

    // Ready depends on the registered count only; no same-cycle pop bypass.
    assign cmd_ready  = !w_full;
    assign w_cmd_hs   = cmd_valid && cmd_ready;
    assign w_push_cmd = '{a: cmd_a, b: cmd_b, op: cmd_op};

`ifdef ALU_SEQ_ILLEGAL_FILTER_EN
    logic w_illegal;
    logic r_err;

    assign w_illegal = is_illegal_op(cmd_op);
    assign w_push    = w_cmd_hs && !w_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      r_err <= 1'b0;
        else if (w_cmd_hs && w_illegal) r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign w_push = w_cmd_hs;
    assign err    = 1'b0;
`endif

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_cmd),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_rsp_hs    = 1'b0;
        alu_opcode  = OP_HOLD;
        alu_a       = r_alu_a;
        alu_b       = r_alu_b;
        case (r_state)
            IDLE: begin
                if (!w_empty) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                alu_a       = w_head.a;
                alu_b       = w_head.b;
                alu_opcode  = w_head.op;
                w_pop       = 1'b1;
                w_state_nxt = CAPTURE;
            end
            CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = RESP;
            end
            RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_rsp_hs = 1'b1;
                    // A push landing on this same edge keeps the pipe moving.
                    w_state_nxt = (!w_empty || w_push) ? ISSUE : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operands keep their last issued value so the ALU inputs stay quiet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_a <= 4'd0;
            r_alu_b <= 4'd0;
        end else if (r_state == ISSUE) begin
            r_alu_a <= w_head.a;
            r_alu_b <= w_head.b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_c     <= 4'd0;
            r_rsp_cf    <= 1'b0;
            r_rsp_zf    <= 1'b1;
            r_rsp_sf    <= 1'b0;
            r_rsp_tag   <= '0;
        end else if (w_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_c     <= alu_c;
            r_rsp_cf    <= alu_cf;
            r_rsp_zf    <= alu_zf;
            r_rsp_sf    <= alu_sf;
        end else if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_rsp_tag   <= r_rsp_tag + 1'b1;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_c     = r_rsp_c;
    assign rsp_cf    = r_rsp_cf;
    assign rsp_zf    = r_rsp_zf;
    assign rsp_sf    = r_rsp_sf;
    assign rsp_tag   = r_rsp_tag;
    assign busy      = (r_state != IDLE) || (w_count != '0);

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
//  Module      : tb_alu_cmd_sequencer
//  Description : Self-checking bench for alu_cmd_sequencer with a registered
//                ALU model attached to its ALU port.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 2;

    typedef struct packed {
        logic [3:0] c;
        logic       cf;
        logic       zf;
        logic       sf;
    } res_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] c;
        logic       cf;
        logic       zf;
        logic       sf;
    } vec_t;

    localparam res_t RES_RST = '{c: 4'd0, cf: 1'b0, zf: 1'b1, sf: 1'b0};

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_a     = 4'd0;
    logic [3:0]       cmd_b     = 4'd0;
    logic [2:0]       cmd_op    = 3'd0;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [2:0]       alu_opcode;
    logic [3:0]       alu_c;
    logic             alu_cf;
    logic             alu_zf;
    logic             alu_sf;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [3:0]       rsp_c;
    logic             rsp_cf;
    logic             rsp_zf;
    logic             rsp_sf;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
    logic             err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rsp_seen_cyc = 0;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_c(alu_c), .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_sf(alu_sf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(rsp_c), .rsp_cf(rsp_cf), .rsp_zf(rsp_zf), .rsp_sf(rsp_sf),
        .rsp_tag(rsp_tag), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Result of one ALU operation; hold (and anything unknown) keeps the old state.
    function automatic res_t alu_ref(input logic [3:0] a, input logic [3:0] b,
                                     input logic [2:0] op, input res_t prev);
        res_t r;
        logic [4:0] s;
        r = prev;
        case (op)
            OP_AND: begin r.c = a & b; r.cf = 1'b0; end
            OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r.c = s[3:0]; r.cf = s[4]; end
            OP_NOR: begin r.c = ~(a | b); r.cf = 1'b0; end
            OP_SUB: begin r.c = a - b; r.cf = (a < b); end
            default: return prev;
        endcase
        r.zf = (r.c == 4'd0);
        r.sf = r.c[3];
        return r;
    endfunction

    // The registered ALU sitting downstream, sharing the sequencer's reset.
    res_t alu_st;
    always @(posedge clk or posedge reset) begin
        if (reset) alu_st <= RES_RST;
        else       alu_st <= alu_ref(alu_a, alu_b, alu_opcode, alu_st);
    end
    assign alu_c  = alu_st.c;
    assign alu_cf = alu_st.cf;
    assign alu_zf = alu_st.zf;
    assign alu_sf = alu_st.sf;

    function automatic logic [8:0] exp9(input res_t r, input logic [1:0] tag);
        return {r, tag};
    endfunction

    function automatic logic [8:0] payload();
        return {rsp_c, rsp_cf, rsp_zf, rsp_sf, rsp_tag};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Entered and left on a falling edge.
    task automatic send_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_accept_timeout", 32'd0, 32'd1);
        else @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input logic [8:0] exp);
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check({name, "_timeout"}, 32'd0, 32'd1);
        else check(name, 32'(payload()), 32'(exp));
        rsp_seen_cyc = cyc;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[12];
        int         n;
        int         t[4];
        logic [8:0] exp_q[$];
        logic [8:0] e;
        res_t       m;
        logic [1:0] m_tag;
        logic       exp_err;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] rop;

        vecs[0]  = '{4'h9, 4'h8, OP_ADD,  4'h1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4'hF, 4'hA, OP_AND,  4'hA, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{4'h0, 4'h0, OP_NOR,  4'hF, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{4'h3, 4'h5, OP_SUB,  4'hE, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{4'h4, 4'h4, OP_ADD,  4'h8, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{4'h5, 4'h5, OP_SUB,  4'h0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{4'h7, 4'h7, OP_HOLD, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{4'hF, 4'h1, OP_ADD,  4'h0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{4'h0, 4'h1, OP_SUB,  4'hF, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{4'hA, 4'h5, OP_NOR,  4'h0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{4'h6, 4'h3, OP_AND,  4'h2, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'h7, 4'h2, OP_SUB,  4'h5, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_cmd_ready",  32'(cmd_ready),  32'd1);
        check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        check("rst_rsp_c",      32'(rsp_c),      32'd0);
        check("rst_rsp_zf",     32'(rsp_zf),     32'd1);
        check("rst_rsp_tag",    32'(rsp_tag),    32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("rst_alu_ab",     32'({alu_a, alu_b}), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_err",        32'(err),        32'd0);

        // Single ADD and its latency
        rsp_ready = 1'b1;
        send_cmd(4'd9, 4'd8, OP_ADD);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("add_latency", 32'(n), 32'd3);
        wait_rsp("add_9_8", exp9('{4'd1, 1'b1, 1'b0, 1'b0}, 2'd0));

        // Reset while the first of three commands sits in CAPTURE
        send_cmd(4'd1, 4'd1, OP_ADD);
        send_cmd(4'd2, 4'd2, OP_ADD);
        send_cmd(4'd3, 4'd3, OP_ADD);
        check("mid_busy_before", 32'(busy), 32'd1);
        check("mid_tag_before", 32'(rsp_tag), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_tag", 32'(rsp_tag), 32'd0);
        check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        check("mid_no_rsp", 32'(n), 32'd0);

        // Back-to-back with rsp_ready held high
        send_cmd(4'hF, 4'hA, OP_AND);
        send_cmd(4'h0, 4'h0, OP_NOR);
        send_cmd(4'h3, 4'h5, OP_SUB);
        send_cmd(4'h4, 4'h4, OP_ADD);
        wait_rsp("b2b_rsp0", exp9('{4'hA, 1'b0, 1'b0, 1'b1}, 2'd0)); t[0] = rsp_seen_cyc;
        wait_rsp("b2b_rsp1", exp9('{4'hF, 1'b0, 1'b0, 1'b1}, 2'd1)); t[1] = rsp_seen_cyc;
        wait_rsp("b2b_rsp2", exp9('{4'hE, 1'b1, 1'b0, 1'b1}, 2'd2)); t[2] = rsp_seen_cyc;
        wait_rsp("b2b_rsp3", exp9('{4'h8, 1'b0, 1'b0, 1'b1}, 2'd3)); t[3] = rsp_seen_cyc;
        for (int i = 1; i < 4; i++)
            check($sformatf("b2b_spacing%0d", i), 32'(t[i] - t[i-1]), 32'd3);

        // Backpressure: five commands offered while the consumer stalls
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_cmd(4'(i), 4'd2, OP_SUB);
        check("bp_cmd_ready_full", 32'(cmd_ready), 32'd0);
        e = exp9(alu_ref(4'd0, 4'd2, OP_SUB, RES_RST), 2'd0);
        repeat (4) begin
            check("bp_hold_stable", 32'({rsp_valid, payload()}), 32'({1'b1, e}));
            @(negedge clk);
        end
        check("bp_cmd_ready_still_full", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 5; i++)
            wait_rsp($sformatf("bp_rsp%0d", i),
                     exp9(alu_ref(4'(i), 4'd2, OP_SUB, RES_RST), 2'(i)));

        // Table of single commands, each issued from idle
        pulse_reset();
        for (int i = 0; i < 12; i++) begin
            send_cmd(vecs[i].a, vecs[i].b, vecs[i].op);
            wait_rsp($sformatf("vec%0d", i),
                     exp9('{vecs[i].c, vecs[i].cf, vecs[i].zf, vecs[i].sf}, 2'(i)));
        end

`ifdef ALU_SEQ_ILLEGAL_FILTER_EN
        // Illegal opcode is swallowed, only the SUB produces a response
        pulse_reset();
        check("flt_err_clear", 32'(err), 32'd0);
        send_cmd(4'd1, 4'd2, 3'b110);
        check("flt_err_set", 32'(err), 32'd1);
        check("flt_not_queued", 32'(busy), 32'd0);
        send_cmd(4'd5, 4'd5, OP_SUB);
        wait_rsp("flt_sub_5_5", exp9('{4'd0, 1'b0, 1'b1, 1'b0}, 2'd0));
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        check("flt_single_rsp", 32'(n), 32'd0);
        check("flt_err_sticky", 32'(err), 32'd1);
`endif

        // Randomised traffic against the in-order reference model
        pulse_reset();
        m = RES_RST;
        m_tag = 2'd0;
        exp_err = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check("rnd_extra_rsp", 32'(payload()), 32'h1FF);
                else begin
                    e = exp_q.pop_front();
                    check("rnd_rsp", 32'(payload()), 32'(e));
                end
            end
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
`ifdef ALU_SEQ_ILLEGAL_FILTER_EN
            rop = 3'($urandom_range(0, 7));
`else
            rop = 3'($urandom_range(0, 4));
`endif
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_a = ra;
            cmd_b = rb;
            cmd_op = rop;
            if (cmd_valid && cmd_ready) begin
`ifdef ALU_SEQ_ILLEGAL_FILTER_EN
                if (rop > OP_SUB) exp_err = 1'b1;
                else begin
`else
                begin
`endif
                    m = alu_ref(ra, rb, rop, m);
                    exp_q.push_back(exp9(m, m_tag));
                    m_tag = m_tag + 2'd1;
                end
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) check("rnd_extra_rsp", 32'(payload()), 32'h1FF);
                else begin
                    e = exp_q.pop_front();
                    check("rnd_drain_rsp", 32'(payload()), 32'(e));
                end
            end
            @(negedge clk);
            n++;
        end
        check("rnd_all_drained", 32'(exp_q.size()), 32'd0);
        check("rnd_idle", 32'(busy), 32'd0);
        check("rnd_err", 32'(err), 32'(exp_err));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
